// File: rtl/cla_pkg.sv
// Shared types and sizing helpers for the pipelined carry-look-ahead adder.
package cla_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic int group_count(input int width, input int stages, input int group);
        return (width / stages) / group;
    endfunction

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit carry-look-ahead block: sum for a given carry-in plus the
// group generate/propagate pair consumed by the group-level look-ahead.
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             ci,
    output logic [GROUP-1:0] s,
    output logic             g,
    output logic             p
);

    logic [GROUP-1:0] gen;
    logic [GROUP-1:0] prop;
    logic [GROUP-1:0] carry;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Every bit carry is a flat sum of products of the bits below it and ci.
    always_comb begin
        logic acc;
        logic pp;
        carry    = '0;
        g        = 1'b0;
        carry[0] = ci;
        for (int i = 0; i < GROUP; i++) begin
            acc = gen[i];
            pp  = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & gen[j]);
                pp  = pp & prop[j];
            end
            if (i < GROUP - 1) begin
                carry[i+1] = acc | (pp & ci);
            end else begin
                g = acc;
            end
        end
    end

    assign p = &prop;
    assign s = prop ^ carry;

endmodule

// File: rtl/cla_adder_pipe.sv
// Skewed-pipeline carry-look-ahead adder, one slice per stage, valid/ready on both sides.
// Optional saturation of the signed result is enabled with `define CLA_PIPE_SAT_EN.
module cla_adder_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_PIPE_SAT_EN
    input  logic             sat_en,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int SW  = slice_width(WIDTH, STAGES);
    localparam int NG  = group_count(WIDTH, STAGES, GROUP);
    localparam int MSB = WIDTH - 1;

    logic             adv;
    logic             v_q   [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_q   [STAGES];
    logic             ovf_q [STAGES];
`ifdef CLA_PIPE_SAT_EN
    logic             sat_q [STAGES];
`endif

    // Global stall: the whole pipe moves only when the output slot is free or being taken.
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = v_q[STAGES-1];
    assign s         = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] op_a;
        logic [WIDTH-1:0] op_b;
        logic [WIDTH-1:0] s_in;
        logic [WIDTH-1:0] s_nx;
        logic             c_in;
        logic             v_in;
        logic             c_out;
        logic             ovf_nx;
        logic [SW-1:0]    ssum;
        logic [NG-1:0]    gc;
        gp_t  [NG-1:0]    gpv;
`ifdef CLA_PIPE_SAT_EN
        logic             sat_in;
`endif

        if (k == 0) begin : g_first
            assign op_a = a;
            assign op_b = b;
            assign s_in = '0;
            assign c_in = cin;
            assign v_in = in_valid;
`ifdef CLA_PIPE_SAT_EN
            assign sat_in = sat_en;
`endif
        end else begin : g_next
            assign op_a = a_q[k-1];
            assign op_b = b_q[k-1];
            assign s_in = s_q[k-1];
            assign c_in = c_q[k-1];
            assign v_in = v_q[k-1];
`ifdef CLA_PIPE_SAT_EN
            assign sat_in = sat_q[k-1];
`endif
        end

        for (genvar j = 0; j < NG; j++) begin : g_grp
            logic gj;
            logic pj;
            cla_group #(.GROUP(GROUP)) u_grp (
                .a  (op_a[k*SW + j*GROUP +: GROUP]),
                .b  (op_b[k*SW + j*GROUP +: GROUP]),
                .ci (gc[j]),
                .s  (ssum[j*GROUP +: GROUP]),
                .g  (gj),
                .p  (pj)
            );
            assign gpv[j] = '{g: gj, p: pj};
        end

        // Group-level look-ahead: each group carry comes straight from the slice carry-in.
        always_comb begin
            logic acc;
            logic pp;
            gc    = '0;
            c_out = 1'b0;
            gc[0] = c_in;
            for (int j = 0; j < NG; j++) begin
                acc = gpv[j].g;
                pp  = gpv[j].p;
                for (int i = j - 1; i >= 0; i--) begin
                    acc = acc | (pp & gpv[i].g);
                    pp  = pp & gpv[i].p;
                end
                if (j < NG - 1) begin
                    gc[j+1] = acc | (pp & c_in);
                end else begin
                    c_out = acc | (pp & c_in);
                end
            end
        end

        // Only the last stage's overflow (and clamp) is meaningful; earlier ones are don't-care.
        always_comb begin
            s_nx              = s_in;
            s_nx[k*SW +: SW]  = ssum;
            ovf_nx            = (op_a[MSB] == op_b[MSB]) && (s_nx[MSB] != op_a[MSB]);
`ifdef CLA_PIPE_SAT_EN
            if ((k == STAGES - 1) && sat_in && ovf_nx) begin
                s_nx = op_a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end
`endif
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q[k]   <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                ovf_q[k] <= 1'b0;
`ifdef CLA_PIPE_SAT_EN
                sat_q[k] <= 1'b0;
`endif
            end else if (adv) begin
                v_q[k]   <= v_in;
                a_q[k]   <= op_a;
                b_q[k]   <= op_b;
                s_q[k]   <= s_nx;
                c_q[k]   <= c_out;
                ovf_q[k] <= ovf_nx;
`ifdef CLA_PIPE_SAT_EN
                sat_q[k] <= sat_in;
`endif
            end
        end
    end

endmodule
